// File: rtl/conc_sched_if.sv
// Code streams from the three Huffman coders and the concatenator input bus.
// master: scheduler view; slave: coder/concatenator environment view.
interface conc_sched_if;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned BIN_W = 24;

    logic [LEN_W-1:0] y_len;
    logic [BIN_W-1:0] y_bin;
    logic             y_eob;
    logic             y_valid;
    logic             y_ready;

    logic [LEN_W-1:0] cb_len;
    logic [BIN_W-1:0] cb_bin;
    logic             cb_eob;
    logic             cb_valid;
    logic             cb_ready;

    logic [LEN_W-1:0] cr_len;
    logic [BIN_W-1:0] cr_bin;
    logic             cr_eob;
    logic             cr_valid;
    logic             cr_ready;

    logic [LEN_W-1:0] out_len;
    logic [BIN_W-1:0] out_bin;
    logic             out_valid;
    logic             out_eoi;

    modport master (
        input  y_len, y_bin, y_eob, y_valid,
        input  cb_len, cb_bin, cb_eob, cb_valid,
        input  cr_len, cr_bin, cr_eob, cr_valid,
        output y_ready, cb_ready, cr_ready,
        output out_len, out_bin, out_valid, out_eoi
    );

    modport slave (
        output y_len, y_bin, y_eob, y_valid,
        output cb_len, cb_bin, cb_eob, cb_valid,
        output cr_len, cr_bin, cr_eob, cr_valid,
        input  y_ready, cb_ready, cr_ready,
        input  out_len, out_bin, out_valid, out_eoi
    );
endinterface

// File: rtl/conc_sched.sv
// Scan scheduler: grants the concatenator input to Y/Cb/Cr in MCU order,
// flags end-of-image on the last code and waits out the 3-cycle EOI flush.
module conc_sched #(
    parameter int unsigned MCU_Y_BLOCKS = 4,
    parameter int unsigned MCU_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic [MCU_CNT_W-1:0] num_mcu,
    output logic                 busy,
    output logic                 done,
    output logic                 len_err,
    conc_sched_if.master         bus
);
    localparam int unsigned LEN_W = 6;
    localparam int unsigned BIN_W = 24;
    localparam int unsigned BLK_W = 3;
    localparam int unsigned DRN_W = 2;

    localparam logic [BLK_W-1:0] CB_BLK   = BLK_W'(MCU_Y_BLOCKS);
    localparam logic [BLK_W-1:0] CR_BLK   = BLK_W'(MCU_Y_BLOCKS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(24);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state;
    logic [BLK_W-1:0]     blk_cnt;
    logic [MCU_CNT_W-1:0] mcu_cnt;
    logic [MCU_CNT_W-1:0] num_q;
    logic [DRN_W-1:0]     drain_cnt;

    logic             sel_valid_c;
    logic             sel_eob_c;
    logic [LEN_W-1:0] sel_len_c;
    logic [BIN_W-1:0] sel_bin_c;
    logic             final_c;
    logic [BLK_W-1:0] nxt_blk_c;

    // Ready registers double as the component select; they are only set in RUN.
    always_comb begin
        sel_valid_c = 1'b0;
        sel_eob_c   = 1'b0;
        sel_len_c   = '0;
        sel_bin_c   = '0;
        if (bus.y_ready) begin
            sel_valid_c = bus.y_valid;
            sel_eob_c   = bus.y_eob;
            sel_len_c   = bus.y_len;
            sel_bin_c   = bus.y_bin;
        end else if (bus.cb_ready) begin
            sel_valid_c = bus.cb_valid;
            sel_eob_c   = bus.cb_eob;
            sel_len_c   = bus.cb_len;
            sel_bin_c   = bus.cb_bin;
        end else if (bus.cr_ready) begin
            sel_valid_c = bus.cr_valid;
            sel_eob_c   = bus.cr_eob;
            sel_len_c   = bus.cr_len;
            sel_bin_c   = bus.cr_bin;
        end
        final_c   = bus.cr_ready && (mcu_cnt == num_q - MCU_CNT_W'(1));
        nxt_blk_c = (blk_cnt == CR_BLK) ? '0 : blk_cnt + BLK_W'(1);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            blk_cnt       <= '0;
            mcu_cnt       <= '0;
            num_q         <= '0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            len_err       <= 1'b0;
            bus.y_ready   <= 1'b0;
            bus.cb_ready  <= 1'b0;
            bus.cr_ready  <= 1'b0;
            bus.out_len   <= '0;
            bus.out_bin   <= '0;
            bus.out_valid <= 1'b0;
            bus.out_eoi   <= 1'b0;
        end else begin
            done          <= 1'b0;
            bus.out_valid <= sel_valid_c;
            bus.out_eoi   <= sel_valid_c && sel_eob_c && final_c;
            if (sel_valid_c) begin
                bus.out_len <= sel_len_c;
                bus.out_bin <= sel_bin_c;
                if (sel_len_c > MAX_LEN) begin
                    len_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start && (num_mcu != '0)) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        num_q       <= num_mcu;
                        blk_cnt     <= '0;
                        mcu_cnt     <= '0;
                        drain_cnt   <= '0;
                        len_err     <= 1'b0;
                        bus.y_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (sel_valid_c && sel_eob_c) begin
                        blk_cnt <= nxt_blk_c;
                        if (blk_cnt == CR_BLK) begin
                            mcu_cnt <= mcu_cnt + MCU_CNT_W'(1);
                        end
                        if (final_c) begin
                            state        <= DRAIN;
                            drain_cnt    <= '0;
                            bus.y_ready  <= 1'b0;
                            bus.cb_ready <= 1'b0;
                            bus.cr_ready <= 1'b0;
                        end else begin
                            bus.y_ready  <= (nxt_blk_c < CB_BLK);
                            bus.cb_ready <= (nxt_blk_c == CB_BLK);
                            bus.cr_ready <= (nxt_blk_c == CR_BLK);
                        end
                    end
                end
                DRAIN: begin
                    // Covers the concatenator's EOI flush before a new image may start.
                    if (drain_cnt == DRN_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conc_sched.sv
// Randomised scoreboard bench for conc_sched: expected output stream is built
// in MCU order from per-component block lists, checked by an output monitor.
module tb_conc_sched;
    localparam int NYB = 4;

    typedef struct packed {
        logic [5:0]  len;
        logic [23:0] bin;
        logic        eob;
    } code_t;

    typedef struct packed {
        logic [5:0]  len;
        logic [23:0] bin;
        logic        eoi;
    } out_t;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [15:0] num_mcu;
    logic        busy;
    logic        done;
    logic        len_err;

    conc_sched_if bus ();

    conc_sched #(.MCU_Y_BLOCKS(NYB), .MCU_CNT_W(16)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .num_mcu (num_mcu),
        .busy    (busy),
        .done    (done),
        .len_err (len_err),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    code_t q_y[$];
    code_t q_cb[$];
    code_t q_cr[$];
    out_t  exp_q[$];

    int vprob[3] = '{100, 100, 100};
    bit arm = 0;
    int tot_blk = 0;
    int stall_at = 0;
    bit exp_err = 0;

    int n_out = 0;
    int first_cyc = 0;
    int eoi_cyc = 0;
    int gaps = 0;
    bit seen_eoi = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference model: a scan is MCU after MCU of NYB Y blocks, one Cb, one Cr.
    task automatic gen_image(input int n, input int ncodes, input int fixlen, input bit err);
        code_t c;
        out_t  o;
        int    k;
        tot_blk = n * (NYB + 2);
        for (int m = 0; m < n; m++) begin
            for (int b = 0; b < NYB + 2; b++) begin
                k = (ncodes == 0) ? int'($urandom_range(3, 1)) : ncodes;
                for (int i = 0; i < k; i++) begin
                    c.len = (fixlen != 0) ? 6'(fixlen) : 6'($urandom_range(24, 0));
                    if (err && m == 0 && b == 0 && i == 0) c.len = 6'd25;
                    c.bin = 24'($urandom);
                    c.eob = (i == k - 1);
                    if (b < NYB)       q_y.push_back(c);
                    else if (b == NYB) q_cb.push_back(c);
                    else               q_cr.push_back(c);
                    o.len = c.len;
                    o.bin = c.bin;
                    o.eoi = (m == n - 1) && (b == NYB + 1) && c.eob;
                    exp_q.push_back(o);
                end
            end
        end
    endtask

    // Coder-side drivers plus a block-count model of which ready must be high.
    bit pv[3];
    bit pr[3];
    bit active = 0;
    int blk_done = 0;
    int y_pops = 0;
    int stall_left = 0;

    always @(negedge clk) begin
        code_t t;
        int pos;
        if (!nrst) begin
            pv = '{0, 0, 0};
            pr = '{0, 0, 0};
            active = 0;
            stall_left = 0;
            bus.y_valid = 1'b0;
            bus.cb_valid = 1'b0;
            bus.cr_valid = 1'b0;
        end else begin
            if (arm) begin
                active = 1;
                arm = 0;
                blk_done = 0;
                y_pops = 0;
            end
            if (pv[0] && pr[0]) begin
                t = q_y.pop_front();
                y_pops++;
                if (t.eob) blk_done++;
                if (stall_at != 0 && y_pops == stall_at) begin
                    stall_left = 5;
                    stall_at = 0;
                end
            end
            if (pv[1] && pr[1]) begin
                t = q_cb.pop_front();
                if (t.eob) blk_done++;
            end
            if (pv[2] && pr[2]) begin
                t = q_cr.pop_front();
                if (t.eob) blk_done++;
            end
            if (active && blk_done == tot_blk) active = 0;
            pos = blk_done % (NYB + 2);
            chk("y_ready",  bus.y_ready,  active && pos < NYB);
            chk("cb_ready", bus.cb_ready, active && pos == NYB);
            chk("cr_ready", bus.cr_ready, active && pos == NYB + 1);

            if (stall_left > 0) begin
                bus.y_valid = 1'b0;
                stall_left--;
            end else if (q_y.size() != 0 && $urandom_range(99, 0) < vprob[0]) begin
                bus.y_valid = 1'b1;
                {bus.y_len, bus.y_bin, bus.y_eob} = q_y[0];
            end else begin
                bus.y_valid = 1'b0;
            end
            if (q_cb.size() != 0 && $urandom_range(99, 0) < vprob[1]) begin
                bus.cb_valid = 1'b1;
                {bus.cb_len, bus.cb_bin, bus.cb_eob} = q_cb[0];
            end else begin
                bus.cb_valid = 1'b0;
            end
            if (q_cr.size() != 0 && $urandom_range(99, 0) < vprob[2]) begin
                bus.cr_valid = 1'b1;
                {bus.cr_len, bus.cr_bin, bus.cr_eob} = q_cr[0];
            end else begin
                bus.cr_valid = 1'b0;
            end
            pv = '{bus.y_valid, bus.cb_valid, bus.cr_valid};
            pr = '{bus.y_ready, bus.cb_ready, bus.cr_ready};
        end
    end

    // Output monitor: pops the scoreboard on every out_valid.
    always @(negedge clk) begin
        out_t e;
        if (nrst) begin
            chk("eoi_without_valid", bus.out_eoi & ~bus.out_valid, 0);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1'b1, exp_q.size() != 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_len", bus.out_len, e.len);
                    chk("out_bin", bus.out_bin, e.bin);
                    chk("out_eoi", bus.out_eoi, e.eoi);
                    if (e.len > 6'd24) exp_err = 1;
                end
                if (n_out == 0) first_cyc = cyc;
                n_out++;
                if (bus.out_eoi) begin
                    eoi_cyc = cyc;
                    seen_eoi = 1;
                end
            end else if (n_out > 0 && !seen_eoi) begin
                gaps++;
            end
            chk("len_err", len_err, exp_err);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_img(input int n);
        start = 1'b1;
        num_mcu = 16'(n);
        arm = 1;
        exp_err = 0;
        n_out = 0;
        gaps = 0;
        seen_eoi = 0;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        num_mcu = 16'(n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < limit) begin
            step();
            k++;
        end
        chk("done_seen", done_cnt != d0, 1);
        chk("busy_at_done", busy, 0);
        chk("done_latency", done_cyc - eoi_cyc, 3);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic wait_flag(input string name, input int target, input int limit);
        int k = 0;
        while (((target < 0) ? !seen_eoi : (n_out < target)) && k < limit) begin
            step();
            k++;
        end
        chk(name, (target < 0) ? seen_eoi : (n_out >= target), 1);
    endtask

    initial begin
        int d0;
        int e1;
        nrst = 1'b0;
        start = 1'b0;
        num_mcu = '0;
        #23;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_out", {bus.out_valid, bus.out_eoi, bus.out_len, bus.out_bin}, 0);
        chk("rst_ready", {bus.y_ready, bus.cb_ready, bus.cr_ready}, 0);
        step();
        nrst = 1'b1;
        step();

        // Single MCU, fixed two-code blocks, everything valid.
        vprob = '{100, 100, 100};
        gen_image(1, 2, 4, 0);
        start_img(1);
        wait_done(200);
        chk("t1_outputs", n_out, 12);
        chk("t1_gaps", gaps, 0);
        chk("t1_eoi_pos", eoi_cyc - first_cyc, 11);

        // Contention: Cb/Cr always valid, Y random; starts in RUN and DRAIN ignored.
        vprob = '{50, 100, 100};
        gen_image(2, 0, 0, 0);
        d0 = done_cnt;
        start_img(2);
        repeat (5) step();
        pulse_start(7);
        chk("run_start_busy", busy, 1);
        wait_flag("t2_eoi_seen", -1, 500);
        pulse_start(3);
        wait_done(50);
        chk("t2_done_once", done_cnt - d0, 1);
        repeat (3) step();
        chk("drain_start_ignored", busy, 0);
        chk("no_extra_done", done_cnt - d0, 1);

        // Y drops valid for 5 cycles in the middle of its first block.
        vprob = '{100, 100, 100};
        gen_image(1, 4, 0, 0);
        stall_at = 2;
        start_img(1);
        wait_done(300);
        chk("t3_outputs", n_out, 24);
        chk("t3_gap", gaps, 5);

        // Back-to-back images: start on the done cycle.
        gen_image(1, 0, 0, 0);
        start_img(1);
        wait_done(300);
        e1 = eoi_cyc;
        gen_image(1, 0, 0, 0);
        start_img(1);
        wait_flag("t4_first_out", 1, 50);
        chk("b2b_first_out", first_cyc - e1, 5);
        wait_done(300);

        // start with num_mcu == 0 is ignored.
        d0 = done_cnt;
        pulse_start(0);
        repeat (4) step();
        chk("zero_mcu_busy", busy, 0);
        chk("zero_mcu_done", done_cnt, d0);

        // Oversize code, then reset mid-MCU, then a clean image.
        gen_image(2, 0, 0, 1);
        start_img(2);
        wait_flag("t6_err_out", 5, 200);
        chk("len_err_set", len_err, 1);
        nrst = 1'b0;
        exp_err = 0;
        #1;
        chk("mid_rst_busy", {busy, done, len_err}, 0);
        chk("mid_rst_out", {bus.out_valid, bus.out_eoi, bus.out_len, bus.out_bin}, 0);
        chk("mid_rst_ready", {bus.y_ready, bus.cb_ready, bus.cr_ready}, 0);
        step();
        q_y.delete();
        q_cb.delete();
        q_cr.delete();
        exp_q.delete();
        step();
        nrst = 1'b1;
        step();
        gen_image(1, 0, 0, 0);
        start_img(1);
        wait_done(300);
        chk("post_rst_len_err", len_err, 0);

        // Randomised images.
        for (int r = 0; r < 4; r++) begin
            int n = int'($urandom_range(3, 1));
            vprob = '{int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                      int'($urandom_range(100, 30))};
            gen_image(n, 0, 0, 0);
            start_img(n);
            wait_done(2000);
            chk("rand_queues_empty", q_y.size() + q_cb.size() + q_cr.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conc_sched.md
# conc_sched

Scan scheduler in front of the byte concatenator in the JPEG encoder. Three Huffman coder streams (Y, Cb, Cr) feed it. It grants the single concatenator input to one component at a time in MCU order: MCU_Y_BLOCKS luma blocks, then one Cb block, then one Cr block. It counts blocks and MCUs, and asserts end-of-image on the final code of the final block. After that it holds off a new image until the concatenator's 3-cycle EOI flush has completed.

## Interface
Parameters:
- MCU_Y_BLOCKS, default 4: luma blocks per MCU. Legal values are 1, 2 and 4.
- MCU_CNT_W, default 16: width of the MCU counter.

Ports:
- clk, input, 1: clock. One clock; reset is asynchronous and active-low.
- nrst, input, 1: asynchronous active-low reset.
- start, input, 1: start of an image. Accepted only in IDLE and only if num_mcu != 0.
- num_mcu, input, MCU_CNT_W: MCUs in the image. Sampled when start is accepted.
- busy, output, 1: high when the state is not IDLE.
- done, output, 1: one-cycle pulse when the EOI flush completes.
- len_err, output, 1: sticky flag, set by any accepted code with len > 24. Cleared by an accepted start.
- y_len / cb_len / cr_len, input, 6: code length, 0..24.
- y_bin / cb_bin / cr_bin, input, 24: code bits, right-aligned.
- y_eob / cb_eob / cr_eob, input, 1: this code is the last code of its 8x8 block.
- y_valid / cb_valid / cr_valid, input, 1: code present.
- y_ready / cb_ready / cr_ready, output, 1: scheduler accepts the code.
- out_len, output, 6: to concatenator in_len.
- out_bin, output, 24: to concatenator in_bin.
- out_valid, output, 1: to concatenator in_valid.
- out_eoi, output, 1: to concatenator in_eoi. Only ever high together with out_valid.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on an accepted start. Accepting start latches num_mcu, clears blk_cnt, mcu_cnt and len_err.
  - RUN -> DRAIN on the handshake of the final block's eob code.
  - DRAIN -> IDLE after 3 cycles, with done pulsed on entry to IDLE.
- start is ignored in RUN and DRAIN. start with num_mcu == 0 is ignored and done is not pulsed.
- blk_cnt runs 0..MCU_Y_BLOCKS+1. The selected component is:
  - Y while blk_cnt < MCU_Y_BLOCKS;
  - Cb when blk_cnt == MCU_Y_BLOCKS;
  - Cr when blk_cnt == MCU_Y_BLOCKS+1.
- Ready signals:
  - In RUN, only the selected component's ready is high. It depends on state and blk_cnt only, never on valid.
  - All ready signals are low in IDLE and DRAIN.
- Handshake is selected valid & ready. On a handshake, len and bin are forwarded unchanged, including len == 0.
- On a handshake with eob:
  - blk_cnt increments, wrapping MCU_Y_BLOCKS+1 -> 0.
  - On the wrap, mcu_cnt increments.
  - The final block is the Cr block with mcu_cnt == num_mcu-1. Its eob handshake also sets out_eoi.
- eob on a non-selected component has no effect, because that component sees no ready.
- Non-selected components are simply stalled; no data is dropped.
- len > 24 sets len_err. The code is still forwarded.
- Asynchronous reset at any point forces IDLE, zero counters and all outputs to their reset values. A partially sent image is abandoned; the concatenator is reset by the same nrst.

## Timing
- Reset values:
  - busy, done, len_err, out_valid, out_eoi are 0.
  - out_len and out_bin are 0.
  - All ready signals are 0.
- out_len, out_bin, out_valid and out_eoi are registered. They appear 1 cycle after the handshake. out_len and out_bin hold their last value while out_valid is 0.
- Throughput is one code per cycle. Consecutive handshakes, including those across a component switch, produce back-to-back out_valid. The new component's ready rises in the cycle after the eob handshake.
- start sampled at cycle S: busy is high and the state is RUN at S+1, and the first handshake can occur at S+1.
- Final eob handshake at cycle T:
  - out_valid = out_eoi = 1 at T+1.
  - DRAIN covers T+1..T+3.
  - At T+4: state IDLE, busy = 0, done = 1.
  - The earliest new start is accepted at T+4. Its first output is at T+6, after the concatenator's flush outputs at T+2..T+4.

## Test plan
- Single MCU, MCU_Y_BLOCKS=4, num_mcu=1, every component always valid, each block = 2 codes (len=4, then len=4 with eob):
  - outputs are Y×8, Cb×2, Cr×2 back-to-back;
  - out_eoi is high only on the 12th output;
  - done is 4 cycles after the last handshake.
- Ordering under contention, num_mcu=2, Cb and Cr valid throughout:
  - cb_ready and cr_ready stay low until the 4th Y eob;
  - outputs follow Y Y Y Y Cb Cr per MCU;
  - out_eoi is set only after the 2nd MCU's Cr eob.
- Selected component drops valid for 5 cycles mid-block:
  - out_valid is low for exactly 5 cycles;
  - blk_cnt is unchanged;
  - no code is duplicated or lost.
- start pulsed during RUN and during DRAIN, plus start with num_mcu=0 in IDLE: all ignored, with no busy or done change.
- Back-to-back images: start asserted at T+4 is accepted, and the first new out_valid is at T+6.
- Code with len=25 in MCU 0, then nrst pulsed mid-MCU:
  - len_err rises and the code is forwarded;
  - reset clears all outputs to 0 and returns to IDLE;
  - a fresh start completes normally with len_err = 0.
